// File: rtl/control_sequencer_pkg.sv
// Shared constants and control-vector types for the FPG8 micro-sequencer:
// opcodes, ALU codes, FSM state encodings and the decoded control bundle.
package control_sequencer_pkg;

  localparam int WORD_W     = 16;
  localparam int ALU_CTRL_W = 3;
  localparam int SEL_W      = 3;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_NOT   = 4'd5;
  localparam logic [3:0] OP_LOAD  = 4'd6;
  localparam logic [3:0] OP_STORE = 4'd7;
  localparam logic [3:0] OP_JMP   = 4'd8;
  localparam logic [3:0] OP_HALT  = 4'd9;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 3'd0;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 3'd1;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 3'd2;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 3'd3;
  localparam logic [ALU_CTRL_W-1:0] ALU_NOT  = 3'd4;
  localparam logic [ALU_CTRL_W-1:0] ALU_PASS = 3'd5;

  localparam logic [2:0] ST_F0   = 3'd0;
  localparam logic [2:0] ST_F1   = 3'd1;
  localparam logic [2:0] ST_F2   = 3'd2;
  localparam logic [2:0] ST_DEC  = 3'd3;
  localparam logic [2:0] ST_E0   = 3'd4;
  localparam logic [2:0] ST_E1   = 3'd5;
  localparam logic [2:0] ST_E2   = 3'd6;
  localparam logic [2:0] ST_HALT = 3'd7;

  // Bus drivers hold for the whole state; strobes get gated by step in the top.
  typedef struct packed {
    logic                  pc_out;
    logic                  mdr_out;
    logic                  z_out;
    logic                  gpr_out;
    logic [SEL_W-1:0]      gpr_select;
    logic [ALU_CTRL_W-1:0] alu_control;
  } bus_ctrl_t;

  typedef struct packed {
    logic mar_in;
    logic mdr_in;
    logic ir_in;
    logic y_in;
    logic z_in;
    logic pc_in;
    logic pc_inc;
    logic gpr_in;
    logic ram_rd;
    logic ram_wr;
  } strobe_t;

  typedef struct packed {
    bus_ctrl_t bus;
    strobe_t   stb;
  } ctrl_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic [ALU_CTRL_W-1:0] alu_for_op(input logic [3:0] op);
    logic [ALU_CTRL_W-1:0] code;
    case (op)
      OP_ADD:  code = ALU_ADD;
      OP_SUB:  code = ALU_SUB;
      OP_AND:  code = ALU_AND;
      OP_OR:   code = ALU_OR;
      OP_NOT:  code = ALU_NOT;
      default: code = ALU_PASS;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/control_sequencer_instr_decode.sv
// Combinational control-store: maps the current micro-state and the latched
// instruction fields to the raw (ungated) bus-drive and strobe vector.
module instr_decode
  import control_sequencer_pkg::*;
(
  input  logic [2:0]       state,
  input  logic [3:0]       opcode,
  input  logic [SEL_W-1:0] rd,
  input  logic [SEL_W-1:0] rs,
  output ctrl_t            ctrl
);

  always_comb begin
    ctrl = '0;
    ctrl.bus.alu_control = ALU_PASS;
    case (state)
      ST_F0: begin
        ctrl.bus.pc_out = 1'b1;
        ctrl.stb.mar_in = 1'b1;
        ctrl.stb.ram_rd = 1'b1;
      end
      ST_F1: begin
        ctrl.stb.mdr_in = 1'b1;
        ctrl.stb.pc_inc = 1'b1;
      end
      ST_F2: begin
        ctrl.bus.mdr_out = 1'b1;
        ctrl.stb.ir_in   = 1'b1;
      end
      ST_E0: begin
        if (is_alu_op(opcode)) begin
          ctrl.bus.gpr_out    = 1'b1;
          ctrl.bus.gpr_select = rs;
          ctrl.stb.y_in       = 1'b1;
        end else if (opcode == OP_NOT) begin
          ctrl.bus.gpr_out     = 1'b1;
          ctrl.bus.gpr_select  = rd;
          ctrl.bus.alu_control = ALU_NOT;
          ctrl.stb.z_in        = 1'b1;
        end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
          ctrl.bus.gpr_out    = 1'b1;
          ctrl.bus.gpr_select = rs;
          ctrl.stb.mar_in     = 1'b1;
          ctrl.stb.ram_rd     = (opcode == OP_LOAD);
        end else if (opcode == OP_JMP) begin
          ctrl.bus.gpr_out    = 1'b1;
          ctrl.bus.gpr_select = rs;
          ctrl.stb.pc_in      = 1'b1;
        end
      end
      ST_E1: begin
        if (is_alu_op(opcode)) begin
          ctrl.bus.gpr_out     = 1'b1;
          ctrl.bus.gpr_select  = rd;
          ctrl.bus.alu_control = alu_for_op(opcode);
          ctrl.stb.z_in        = 1'b1;
        end else if (opcode == OP_NOT) begin
          ctrl.bus.z_out      = 1'b1;
          ctrl.bus.gpr_select = rd;
          ctrl.stb.gpr_in     = 1'b1;
        end else if (opcode == OP_LOAD) begin
          ctrl.stb.mdr_in = 1'b1;
        end else if (opcode == OP_STORE) begin
          ctrl.bus.gpr_out    = 1'b1;
          ctrl.bus.gpr_select = rd;
          ctrl.stb.mdr_in     = 1'b1;
        end
      end
      ST_E2: begin
        if (is_alu_op(opcode)) begin
          ctrl.bus.z_out      = 1'b1;
          ctrl.bus.gpr_select = rd;
          ctrl.stb.gpr_in     = 1'b1;
        end else if (opcode == OP_LOAD) begin
          ctrl.bus.mdr_out    = 1'b1;
          ctrl.bus.gpr_select = rd;
          ctrl.stb.gpr_in     = 1'b1;
        end else if (opcode == OP_STORE) begin
          ctrl.stb.ram_wr = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Step-gated fetch/decode/execute Moore FSM for the FPG8 single-bus datapath.
// Each step pulse advances one micro-state; strobes fire only in that cycle.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  step,
  input  logic [WORD_W-1:0]     ir,
  output logic                  pc_out,
  output logic                  mar_in,
  output logic                  mdr_in,
  output logic                  mdr_out,
  output logic                  ir_in,
  output logic                  y_in,
  output logic                  z_in,
  output logic                  z_out,
  output logic                  pc_in,
  output logic                  pc_inc,
  output logic                  gpr_in,
  output logic                  gpr_out,
  output logic [SEL_W-1:0]      gpr_select,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  ram_enable_read,
  output logic                  ram_enable_write,
  output logic                  halted,
  output logic                  illegal,
  output logic [2:0]            state_dbg
);

  logic [2:0]       state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [SEL_W-1:0] rd_q, rd_d, rs_q, rs_d;
  logic [3:0]       ir_op;
  logic             unused_ir;
  ctrl_t            ctrl;
  logic             gate;

  assign ir_op     = ir[15:12];
  assign unused_ir = ^ir[5:0];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rs_d    = rs_q;
    if (step) begin
      case (state_q)
        ST_F0: state_d = ST_F1;
        ST_F1: state_d = ST_F2;
        ST_F2: state_d = ST_DEC;
        ST_DEC: begin
          op_d = ir_op;
          rd_d = ir[11:9];
          rs_d = ir[8:6];
          if (ir_op == OP_HALT)                             state_d = ST_HALT;
          else if (ir_op == OP_NOP || ir_op > OP_HALT)      state_d = ST_F0;
          else                                              state_d = ST_E0;
        end
        ST_E0:   state_d = (op_q == OP_JMP) ? ST_F0 : ST_E1;
        ST_E1:   state_d = (op_q == OP_NOT) ? ST_F0 : ST_E2;
        ST_E2:   state_d = ST_F0;
        default: state_d = ST_HALT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_F0;
      op_q    <= OP_NOP;
      rd_q    <= '0;
      rs_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      rs_q    <= rs_d;
    end
  end

  instr_decode u_decode (
    .state  (state_q),
    .opcode (op_q),
    .rd     (rd_q),
    .rs     (rs_q),
    .ctrl   (ctrl)
  );

  // Outputs are forced low combinationally by reset so an aborted strobe drops at once.
  assign gate = reset & step;

  assign pc_out      = reset & ctrl.bus.pc_out;
  assign mdr_out     = reset & ctrl.bus.mdr_out;
  assign z_out       = reset & ctrl.bus.z_out;
  assign gpr_out     = reset & ctrl.bus.gpr_out;
  assign gpr_select  = reset ? ctrl.bus.gpr_select : '0;
  assign alu_control = reset ? ctrl.bus.alu_control : ALU_PASS;

  assign mar_in           = gate & ctrl.stb.mar_in;
  assign mdr_in           = gate & ctrl.stb.mdr_in;
  assign ir_in            = gate & ctrl.stb.ir_in;
  assign y_in             = gate & ctrl.stb.y_in;
  assign z_in             = gate & ctrl.stb.z_in;
  assign pc_in            = gate & ctrl.stb.pc_in;
  assign pc_inc           = gate & ctrl.stb.pc_inc;
  assign gpr_in           = gate & ctrl.stb.gpr_in;
  assign ram_enable_read  = gate & ctrl.stb.ram_rd;
  assign ram_enable_write = gate & ctrl.stb.ram_wr;

  assign halted    = reset & (state_q == ST_HALT);
  assign illegal   = gate & (state_q == ST_DEC) & (ir_op > OP_HALT);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a micro-step plan model (queue of expected
// control records per instruction) checked every negedge, plus directed literals.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        step = 1'b0;
  logic [15:0] ir = 16'h0000;
  logic        pc_out, mar_in, mdr_in, mdr_out, ir_in, y_in, z_in, z_out;
  logic        pc_in, pc_inc, gpr_in, gpr_out, ram_rd, ram_wr, halted, illegal;
  logic [2:0]  gpr_select, alu_control, state_dbg;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  control_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .step             (step),
    .ir               (ir),
    .pc_out           (pc_out),
    .mar_in           (mar_in),
    .mdr_in           (mdr_in),
    .mdr_out          (mdr_out),
    .ir_in            (ir_in),
    .y_in             (y_in),
    .z_in             (z_in),
    .z_out            (z_out),
    .pc_in            (pc_in),
    .pc_inc           (pc_inc),
    .gpr_in           (gpr_in),
    .gpr_out          (gpr_out),
    .gpr_select       (gpr_select),
    .alu_control      (alu_control),
    .ram_enable_read  (ram_rd),
    .ram_enable_write (ram_wr),
    .halted           (halted),
    .illegal          (illegal),
    .state_dbg        (state_dbg)
  );

  // ---------------- model: queue of planned micro-steps ----------------
  typedef struct packed {
    logic       pc_out, mdr_out, z_out, gpr_out;
    logic [2:0] sel, alu;
    logic       mar_in, mdr_in, ir_in, y_in, z_in, pc_in, pc_inc, gpr_in, rd, wr;
    logic       halted, is_dec;
  } step_t;

  step_t exp_q[$];

  function automatic step_t idle_s();
    step_t s;
    s = '0;
    s.alu = 3'd5;
    return s;
  endfunction

  task automatic push_fetch();
    step_t s;
    s = idle_s(); s.pc_out = 1; s.mar_in = 1; s.rd = 1; exp_q.push_back(s);
    s = idle_s(); s.mdr_in = 1; s.pc_inc = 1;           exp_q.push_back(s);
    s = idle_s(); s.mdr_out = 1; s.ir_in = 1;           exp_q.push_back(s);
    s = idle_s(); s.is_dec = 1;                         exp_q.push_back(s);
  endtask

  task automatic push_exec(input logic [15:0] instr);
    step_t s;
    logic [3:0] op;
    logic [2:0] rd, rs;
    op = instr[15:12]; rd = instr[11:9]; rs = instr[8:6];
    if (op >= 4'd1 && op <= 4'd4) begin
      s = idle_s(); s.gpr_out = 1; s.sel = rs; s.y_in = 1; exp_q.push_back(s);
      s = idle_s(); s.gpr_out = 1; s.sel = rd; s.alu = 3'(op - 4'd1); s.z_in = 1;
      exp_q.push_back(s);
      s = idle_s(); s.z_out = 1; s.gpr_in = 1; s.sel = rd; exp_q.push_back(s);
    end else if (op == 4'd5) begin
      s = idle_s(); s.gpr_out = 1; s.sel = rd; s.alu = 3'd4; s.z_in = 1; exp_q.push_back(s);
      s = idle_s(); s.z_out = 1; s.gpr_in = 1; s.sel = rd; exp_q.push_back(s);
    end else if (op == 4'd6) begin
      s = idle_s(); s.gpr_out = 1; s.sel = rs; s.mar_in = 1; s.rd = 1; exp_q.push_back(s);
      s = idle_s(); s.mdr_in = 1; exp_q.push_back(s);
      s = idle_s(); s.mdr_out = 1; s.gpr_in = 1; s.sel = rd; exp_q.push_back(s);
    end else if (op == 4'd7) begin
      s = idle_s(); s.gpr_out = 1; s.sel = rs; s.mar_in = 1; exp_q.push_back(s);
      s = idle_s(); s.gpr_out = 1; s.sel = rd; s.mdr_in = 1; exp_q.push_back(s);
      s = idle_s(); s.wr = 1; exp_q.push_back(s);
    end else if (op == 4'd8) begin
      s = idle_s(); s.gpr_out = 1; s.sel = rs; s.pc_in = 1; exp_q.push_back(s);
    end else if (op == 4'd9) begin
      s = idle_s(); s.halted = 1; exp_q.push_back(s);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    step_t cur;
    if (!reset) begin
      exp_q.delete();
      push_fetch();
    end else if (step) begin
      cur = exp_q.pop_front();
      if (cur.halted) exp_q.push_front(cur);
      else if (cur.is_dec) push_exec(ir);
      if (exp_q.size() == 0) push_fetch();
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    step_t e;
    logic  ill;
    if (!reset || exp_q.size() == 0) begin
      e = idle_s();
      ill = 1'b0;
    end else begin
      e = exp_q[0];
      ill = e.is_dec && step && (ir[15:12] > 4'd9);
      if (!step) begin
        e.mar_in = 0; e.mdr_in = 0; e.ir_in = 0; e.y_in = 0; e.z_in = 0;
        e.pc_in = 0; e.pc_inc = 0; e.gpr_in = 0; e.rd = 0; e.wr = 0;
      end
    end
    chk("pc_out", 8'(pc_out), 8'(e.pc_out));
    chk("mdr_out", 8'(mdr_out), 8'(e.mdr_out));
    chk("z_out", 8'(z_out), 8'(e.z_out));
    chk("gpr_out", 8'(gpr_out), 8'(e.gpr_out));
    chk("gpr_select", 8'(gpr_select), 8'(e.sel));
    chk("alu_control", 8'(alu_control), 8'(e.alu));
    chk("mar_in", 8'(mar_in), 8'(e.mar_in));
    chk("mdr_in", 8'(mdr_in), 8'(e.mdr_in));
    chk("ir_in", 8'(ir_in), 8'(e.ir_in));
    chk("y_in", 8'(y_in), 8'(e.y_in));
    chk("z_in", 8'(z_in), 8'(e.z_in));
    chk("pc_in", 8'(pc_in), 8'(e.pc_in));
    chk("pc_inc", 8'(pc_inc), 8'(e.pc_inc));
    chk("gpr_in", 8'(gpr_in), 8'(e.gpr_in));
    chk("ram_read", 8'(ram_rd), 8'(e.rd));
    chk("ram_write", 8'(ram_wr), 8'(e.wr));
    chk("halted", 8'(halted), 8'(e.halted));
    chk("illegal", 8'(illegal), 8'(ill));
    chk("one_driver", 8'(int'(pc_out) + int'(mdr_out) + int'(z_out) + int'(gpr_out) > 1), 8'd0);
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic s);
    @(posedge clk);
    #1 step = s;
    @(negedge clk);
    #1;
  endtask

  task automatic fetch_to_dec();
    repeat (4) cyc(1'b1);
  endtask

  // ---------------- directed stimulus ----------------
  logic [15:0] prog [10] = '{16'h26C0, 16'h5800, 16'h6580, 16'h81C0, 16'h0000,
                             16'h3040, 16'h4D40, 16'hF123, 16'h2A40, 16'h7000};

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_alu", 8'(alu_control), 8'd5);
    chk("rst_pc_out", 8'(pc_out), 8'd0);
    @(posedge clk); #1 reset = 1'b1; ir = 16'h1280;
    @(negedge clk); #1;
    chk("f0_idle_pc_out", 8'(pc_out), 8'd1);
    chk("f0_idle_mar_in", 8'(mar_in), 8'd0);

    // ADD R1,R2 fetch and execute
    cyc(1); chk("f0_mar_in", 8'(mar_in), 8'd1);
    cyc(1); chk("f1_mdr_in", 8'(mdr_in), 8'd1); chk("f1_pc_inc", 8'(pc_inc), 8'd1);
    cyc(1); chk("f2_ir_in", 8'(ir_in), 8'd1);
    cyc(1);
    cyc(1); chk("add_e0_sel", 8'(gpr_select), 8'd2); chk("add_e0_y_in", 8'(y_in), 8'd1);
    repeat (10) begin
      cyc(0); chk("hold_z_in", 8'(z_in), 8'd0); chk("hold_sel", 8'(gpr_select), 8'd1);
      chk("hold_gpr_out", 8'(gpr_out), 8'd1);
    end
    cyc(1); chk("add_e1_alu", 8'(alu_control), 8'd0); chk("add_e1_z_in", 8'(z_in), 8'd1);
    cyc(1); chk("add_e2_z_out", 8'(z_out), 8'd1); chk("add_e2_gpr_in", 8'(gpr_in), 8'd1);
    cyc(0); chk("add_back_f0", 8'(pc_out), 8'd1);

    // STORE [R1],R5
    ir = 16'h7A40;
    fetch_to_dec();
    cyc(1); chk("st_e0_sel", 8'(gpr_select), 8'd1); chk("st_e0_mar", 8'(mar_in), 8'd1);
    cyc(1); chk("st_e1_sel", 8'(gpr_select), 8'd5); chk("st_e1_mdr", 8'(mdr_in), 8'd1);
    cyc(1); chk("st_e2_wr", 8'(ram_wr), 8'd1);
    cyc(0); chk("st_wr_done", 8'(ram_wr), 8'd0);

    // reset asserted mid-E1 of an ADD
    ir = 16'h1280;
    fetch_to_dec();
    cyc(1); cyc(1);
    chk("pre_rst_z_in", 8'(z_in), 8'd1);
    reset = 1'b0; #1;
    chk("mid_rst_z_in", 8'(z_in), 8'd0);
    chk("mid_rst_gpr_out", 8'(gpr_out), 8'd0);
    chk("mid_rst_alu", 8'(alu_control), 8'd5);
    @(posedge clk); #1 reset = 1'b1; step = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_f0", 8'(pc_out), 8'd1);

    // illegal opcode
    ir = 16'hB000;
    fetch_to_dec();
    chk("illegal_pulse", 8'(illegal), 8'd1);
    cyc(0); chk("illegal_gone", 8'(illegal), 8'd0); chk("illegal_f0", 8'(pc_out), 8'd1);

    // mixed program with irregular stepping
    foreach (prog[i]) begin
      ir = prog[i];
      for (int k = 0; k < 9; k++) cyc(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end
    for (int k = 0; k < 8; k++) cyc(1'b1);

    // HALT is sticky
    step = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    ir = 16'h9000;
    fetch_to_dec();
    repeat (20) cyc(1);
    chk("halt_sticky", 8'(halted), 8'd1);
    chk("halt_no_strobe", 8'(mar_in | ram_rd | ram_wr | pc_inc), 8'd0);
    cyc(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
